// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data cache memory arbiter.
// The block geometry defaults are also used by the icache and dcache modules.
package mem_arbiter_pkg;

  localparam int ARB_ADDR_W  = 28;   // byte address bits [31:4]
  localparam int ARB_BLOCK_W = 128;  // four 32-bit words per block
  localparam int STARVE_W    = 4;    // holds STARVE_LIMIT values 1..15

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_D = 2'd1,
    ARB_SERVE_I = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side block-transfer signals of the arbiter.
// master is the arbiter's view; slave is the view of the caches plus memory.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int BLOCK_W = ARB_BLOCK_W
);

  logic               i_read;
  logic [ADDR_W-1:0]  i_addr;
  logic [BLOCK_W-1:0] i_readdata;
  logic               i_busywait;

  logic               d_read;
  logic               d_write;
  logic [ADDR_W-1:0]  d_addr;
  logic [BLOCK_W-1:0] d_writedata;
  logic [BLOCK_W-1:0] d_readdata;
  logic               d_busywait;

  logic               mem_read;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_addr;
  logic [BLOCK_W-1:0] mem_writedata;
  logic [BLOCK_W-1:0] mem_readdata;
  logic               mem_done;

  logic [1:0]         grant_debug;

  modport master (
    input  i_read, i_addr, d_read, d_write, d_addr, d_writedata,
           mem_readdata, mem_done,
    output i_readdata, i_busywait, d_readdata, d_busywait,
           mem_read, mem_write, mem_addr, mem_writedata, grant_debug
  );

  modport slave (
    output i_read, i_addr, d_read, d_write, d_addr, d_writedata,
           mem_readdata, mem_done,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
           mem_read, mem_write, mem_addr, mem_writedata, grant_debug
  );

endinterface

// File: rtl/mem_arbiter.sv
// Grants the single memory block port to the dcache (fixed priority) or the
// icache, with a starvation limit that guarantees instruction fetch progress.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int BLOCK_W      = ARB_BLOCK_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  mem_arbiter_if.master bus
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_LIMIT[STARVE_W-1:0];

  arb_state_t         state_reg;
  logic               mem_read_reg;
  logic               mem_write_reg;
  logic [ADDR_W-1:0]  mem_addr_reg;
  logic [BLOCK_W-1:0] mem_writedata_reg;
  logic [BLOCK_W-1:0] i_readdata_reg;
  logic [BLOCK_W-1:0] d_readdata_reg;
  logic [STARVE_W-1:0] starve_cnt_reg;
  logic               done_i_reg;
  logic               done_d_reg;

  logic d_req;
  logic i_req;
  logic starve_full;

  assign d_req       = bus.d_read | bus.d_write;
  assign i_req       = bus.i_read;
  assign starve_full = (starve_cnt_reg == STARVE_MAX);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg         <= ARB_IDLE;
      mem_read_reg      <= 1'b0;
      mem_write_reg     <= 1'b0;
      mem_addr_reg      <= '0;
      mem_writedata_reg <= '0;
      i_readdata_reg    <= '0;
      d_readdata_reg    <= '0;
      starve_cnt_reg    <= '0;
      done_i_reg        <= 1'b0;
      done_d_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (d_req && !(i_req && starve_full)) begin
            state_reg         <= ARB_SERVE_D;
            mem_addr_reg      <= bus.d_addr;
            mem_writedata_reg <= bus.d_writedata;
            // A pending write-back always goes out before the refill read.
            mem_write_reg     <= bus.d_write;
            mem_read_reg      <= ~bus.d_write;
            if (i_req && !starve_full) begin
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
          end else if (i_req) begin
            state_reg      <= ARB_SERVE_I;
            mem_addr_reg   <= bus.i_addr;
            mem_read_reg   <= 1'b1;
            mem_write_reg  <= 1'b0;
            starve_cnt_reg <= '0;
          end
        end

        ARB_SERVE_D: begin
          if (bus.mem_done) begin
            if (mem_read_reg) begin
              d_readdata_reg <= bus.mem_readdata;
            end
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            done_d_reg    <= 1'b1;
            state_reg     <= ARB_RELEASE;
          end
        end

        ARB_SERVE_I: begin
          if (bus.mem_done) begin
            i_readdata_reg <= bus.mem_readdata;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            done_i_reg     <= 1'b1;
            state_reg      <= ARB_RELEASE;
          end
        end

        ARB_RELEASE: begin
          done_i_reg <= 1'b0;
          done_d_reg <= 1'b0;
          state_reg  <= ARB_IDLE;
        end

        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  // Combinational so a fresh request stalls its pipeline in the same cycle.
  assign bus.i_busywait = i_req & ~done_i_reg;
  assign bus.d_busywait = d_req & ~done_d_reg;

  assign bus.i_readdata    = i_readdata_reg;
  assign bus.d_readdata    = d_readdata_reg;
  assign bus.mem_read      = mem_read_reg;
  assign bus.mem_write     = mem_write_reg;
  assign bus.mem_addr      = mem_addr_reg;
  assign bus.mem_writedata = mem_writedata_reg;
  assign bus.grant_debug   = state_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: lone fetch, write-back precedence,
// starvation limit, back-to-back grants, spurious MEM_DONE and async reset.
module tb_mem_arbiter;

  localparam int ADDR_W  = 28;
  localparam int BLOCK_W = 128;

  localparam logic [127:0] DATA1 = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [127:0] WB    = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] JUNK  = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;
  localparam logic [127:0] R2    = 128'h00000002_00000002_00000002_00000002;
  localparam logic [127:0] R3    = 128'h00000003_00000003_00000003_00000003;
  localparam logic [127:0] R4    = 128'h00000004_00000004_00000004_00000004;
  localparam logic [127:0] R5    = 128'h00000005_00000005_00000005_00000005;
  localparam logic [127:0] R6    = 128'h00000006_00000006_00000006_00000006;
  localparam logic [127:0] R7    = 128'h00000007_00000007_00000007_00000007;

  logic CLK;
  logic RESET;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();

  mem_arbiter #(
    .ADDR_W      (ADDR_W),
    .BLOCK_W     (BLOCK_W),
    .STARVE_LIMIT(4)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic done_pulse(input logic [127:0] data);
    bus.mem_done     = 1'b1;
    bus.mem_readdata = data;
  endtask

  initial begin
    RESET = 1'b1;
    bus.i_read = 1'b0;  bus.i_addr = '0;
    bus.d_read = 1'b0;  bus.d_write = 1'b0;
    bus.d_addr = '0;    bus.d_writedata = '0;
    bus.mem_readdata = '0; bus.mem_done = 1'b0;

    #12;
    chk("rst_grant", 128'(bus.grant_debug), 128'd0);
    chk("rst_mem_read", 128'(bus.mem_read), 128'd0);
    chk("rst_mem_write", 128'(bus.mem_write), 128'd0);
    chk("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
    chk("rst_mem_wdata", bus.mem_writedata, 128'd0);
    chk("rst_i_rdata", bus.i_readdata, 128'd0);
    chk("rst_d_rdata", bus.d_readdata, 128'd0);
    RESET = 1'b0;
    tick();

    // Lone I read, memory answers in the third strobe cycle.
    bus.i_read = 1'b1; bus.i_addr = 28'h0000010;
    #1;
    chk("i1_c0_grant", 128'(bus.grant_debug), 128'd0);
    chk("i1_c0_busy", 128'(bus.i_busywait), 128'd1);
    tick();
    chk("i1_c1_grant", 128'(bus.grant_debug), 128'd2);
    chk("i1_c1_mread", 128'(bus.mem_read), 128'd1);
    chk("i1_c1_maddr", 128'(bus.mem_addr), 128'h10);
    tick();
    chk("i1_c2_grant", 128'(bus.grant_debug), 128'd2);
    chk("i1_c2_mread", 128'(bus.mem_read), 128'd1);
    tick();
    chk("i1_c3_grant", 128'(bus.grant_debug), 128'd2);
    chk("i1_c3_busy", 128'(bus.i_busywait), 128'd1);
    done_pulse(DATA1);
    tick();
    bus.mem_done = 1'b0;
    chk("i1_c4_grant", 128'(bus.grant_debug), 128'd3);
    chk("i1_c4_busy", 128'(bus.i_busywait), 128'd0);
    chk("i1_c4_rdata", bus.i_readdata, DATA1);
    chk("i1_c4_mread", 128'(bus.mem_read), 128'd0);
    bus.i_read = 1'b0;
    tick();
    chk("i1_c5_grant", 128'(bus.grant_debug), 128'd0);

    // D write-back + D refill + I read all pending: write goes first.
    bus.d_write = 1'b1; bus.d_read = 1'b1; bus.i_read = 1'b1;
    bus.i_addr = 28'h0000020; bus.d_addr = 28'h0000ABC; bus.d_writedata = WB;
    #1;
    chk("wb_c0_dbusy", 128'(bus.d_busywait), 128'd1);
    tick();
    chk("wb_grant", 128'(bus.grant_debug), 128'd1);
    chk("wb_mwrite", 128'(bus.mem_write), 128'd1);
    chk("wb_mread", 128'(bus.mem_read), 128'd0);
    chk("wb_mwdata", bus.mem_writedata, WB);
    chk("wb_maddr", 128'(bus.mem_addr), 128'hABC);
    chk("wb_ibusy", 128'(bus.i_busywait), 128'd1);
    done_pulse(JUNK);
    tick();
    chk("wb_rel_grant", 128'(bus.grant_debug), 128'd3);
    chk("wb_rel_dbusy", 128'(bus.d_busywait), 128'd0);
    chk("wb_rel_ibusy", 128'(bus.i_busywait), 128'd1);
    chk("wb_rel_drdata", bus.d_readdata, 128'd0);
    chk("wb_rel_mwrite", 128'(bus.mem_write), 128'd0);
    // MEM_DONE stays high through RELEASE and must be ignored.
    bus.d_write = 1'b0;
    tick();
    bus.mem_done = 1'b0;
    chk("rel_spur_grant", 128'(bus.grant_debug), 128'd0);
    chk("rel_spur_drdata", bus.d_readdata, 128'd0);
    chk("b2b_gap_dbusy", 128'(bus.d_busywait), 128'd1);
    chk("b2b_gap_mread", 128'(bus.mem_read), 128'd0);
    tick();
    chk("d2_grant", 128'(bus.grant_debug), 128'd1);
    chk("d2_mread", 128'(bus.mem_read), 128'd1);
    done_pulse(R2);
    tick();
    bus.mem_done = 1'b0;
    chk("d2_rdata", bus.d_readdata, R2);
    chk("d2_dbusy", 128'(bus.d_busywait), 128'd0);
    tick();
    chk("d2_gap_dbusy", 128'(bus.d_busywait), 128'd1);
    chk("d2_gap_mread", 128'(bus.mem_read), 128'd0);
    tick();
    chk("d3_grant", 128'(bus.grant_debug), 128'd1);
    done_pulse(R3);
    tick();
    bus.mem_done = 1'b0;
    chk("d3_rdata", bus.d_readdata, R3);
    tick();
    tick();
    chk("d4_grant", 128'(bus.grant_debug), 128'd1);
    done_pulse(R4);
    tick();
    bus.mem_done = 1'b0;
    chk("d4_rdata", bus.d_readdata, R4);
    chk("d4_ibusy", 128'(bus.i_busywait), 128'd1);
    tick();
    chk("d4_idle", 128'(bus.grant_debug), 128'd0);
    tick();
    // Fifth arbitration: limit reached, I must win.
    chk("starve_grant_i", 128'(bus.grant_debug), 128'd2);
    chk("starve_maddr", 128'(bus.mem_addr), 128'h20);
    chk("starve_dbusy", 128'(bus.d_busywait), 128'd1);
    done_pulse(R5);
    tick();
    bus.mem_done = 1'b0;
    chk("starve_rel_grant", 128'(bus.grant_debug), 128'd3);
    chk("starve_irdata", bus.i_readdata, R5);
    chk("starve_ibusy", 128'(bus.i_busywait), 128'd0);
    chk("starve_drdata", bus.d_readdata, R4);
    tick();
    tick();
    // Counter cleared by the I grant: D wins again with both pending.
    chk("post_i_grant_d", 128'(bus.grant_debug), 128'd1);
    done_pulse(R6);
    tick();
    bus.mem_done = 1'b0;
    bus.d_read = 1'b0;
    tick();
    tick();
    chk("i2_grant", 128'(bus.grant_debug), 128'd2);

    // Asynchronous reset in the middle of SERVE_I.
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_mread", 128'(bus.mem_read), 128'd0);
    chk("arst_grant", 128'(bus.grant_debug), 128'd0);
    chk("arst_irdata", bus.i_readdata, 128'd0);
    chk("arst_ibusy", 128'(bus.i_busywait), 128'd1);
    #2;
    RESET = 1'b0;
    tick();
    chk("arst_regrant", 128'(bus.grant_debug), 128'd2);
    chk("arst_regrant_mread", 128'(bus.mem_read), 128'd1);
    done_pulse(R7);
    tick();
    bus.mem_done = 1'b0;
    chk("arst_irdata2", bus.i_readdata, R7);
    bus.i_read = 1'b0;
    tick();

    // Spurious MEM_DONE while idle with nothing pending.
    done_pulse(JUNK);
    tick();
    bus.mem_done = 1'b0;
    chk("idle_spur_grant", 128'(bus.grant_debug), 128'd0);
    chk("idle_spur_irdata", bus.i_readdata, R7);
    chk("idle_spur_drdata", bus.d_readdata, 128'd0);
    chk("idle_spur_mread", 128'(bus.mem_read), 128'd0);
    tick();
    chk("idle_spur_grant2", 128'(bus.grant_debug), 128'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
